lcd_text_ctrl: RTL and testbench
================================

Name: lcd_text_ctrl

Overview:
Parametrised ST7920-class character LCD controller for the 8-bit parallel bus. It is the successor to the fixed 4x16 screen driver. It holds a host-writable text buffer of ROWS x COLS bytes and runs the power-on init sequence. Frames are then streamed to the panel either continuously or on demand, with busy and frame_done handshakes, so the panel can be driven by the lock/phone application logic.

Parameters:
CLK_DIV, 8000, clk_50M cycles per E half-period; one bus slot is 2*CLK_DIV cycles; even, >=4
ROWS, 4, text rows; legal values 1, 2, 4
COLS, 16, bytes per row; 2..16, even
INIT_SLOTS, 8, idle slots after reset before the first command
CLEAR_SLOTS, 6, idle slots after the clear command (0x01)
AUTO_REFRESH, 1, 1 = loop frames forever; 0 = send a frame only on request or dirty buffer

Ports:
clk_50M  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  text-buffer write strobe
wr_addr  in  AW=$clog2(ROWS*COLS)  buffer address, row*COLS+col
wr_data  in  8  byte to store (ASCII or GB2312 half-code)
refresh  in  1  one-cycle frame request (ignored when AUTO_REFRESH=1)
busy  out  1  high during init or a frame in progress
frame_done  out  1  one-cycle pulse at the end of each frame
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  constant 0
lcd_e  out  1  enable strobe
lcd_data  out  8  bus data

Behaviour:
- Clock, reset and polarity: one clock, clk_50M. rst is synchronous and active-high.
- Reset values: lcd_e=0, lcd_rs=0, lcd_data=0x00, busy=1, frame_done=0. Slot counter is 0. All buffer bytes are 0x20. Any pending refresh and the dirty flag are cleared. A reset mid-frame aborts the frame immediately and restarts init from the beginning.
- Slot timing: counter s runs 0..2*CLK_DIV-1 and wraps.
  - Bus slot: lcd_rs and lcd_data are updated at s==CLK_DIV/2. lcd_e=1 for s in [CLK_DIV, 2*CLK_DIV-1], else 0. The panel latches on the falling edge of E. Setup and hold are each CLK_DIV/2 cycles.
  - Idle slot: lcd_e stays 0 and the bus holds its value.
- State machine, one state per slot:
  - INIT_WAIT: INIT_SLOTS idle slots.
  - Command slots in order: 0x30, 0x30, 0x0C, 0x01.
  - CLR_WAIT: CLEAR_SLOTS idle slots.
  - Command 0x06.
  - Then FRAME if AUTO_REFRESH=1, else IDLE.
- FRAME: for each row r = 0..ROWS-1, one address command slot (rs=0), then COLS data slots (rs=1) carrying buffer[r*COLS+0 .. r*COLS+COLS-1] in order.
  - Row addresses: r0=0x80, r1=0x90, r2=0x88, r3=0x98.
  - A frame is ROWS*(COLS+1) slots.
- End of frame: frame_done pulses on the final cycle of the last data slot (s==2*CLK_DIV-1).
  - AUTO_REFRESH=1: the next frame starts in the following slot; busy stays 1.
  - AUTO_REFRESH=0: enter IDLE with busy=0, unless pending or dirty is set, in which case another frame starts immediately.
- IDLE (AUTO_REFRESH=0 only):
  - lcd_e=0, busy=0.
  - refresh or dirty starts a frame at the next slot boundary. busy rises the cycle after the request.
  - pending is cleared when the frame starts.
  - refresh while busy sets pending; repeated requests coalesce into one further frame.
- Buffer writes: accepted in every state, one per cycle, with no stall.
  - The write lands at the next edge and sets dirty.
  - dirty is cleared at the start of a frame.
  - A data slot samples its byte at s==CLK_DIV/2. A write to that same address in that same cycle is not shown in this frame, but dirty guarantees a following frame when AUTO_REFRESH=0.
  - When wr_addr >= ROWS*COLS, the write is ignored and dirty is unchanged.
- lcd_data is never tri-stated; lcd_rw is tied to 0 (write-only, no busy-flag polling).

Test Plan:
1. Init sequence (CLK_DIV=4, INIT_SLOTS=2, CLEAR_SLOTS=2, AUTO_REFRESH=0):
   - Stimulus: release rst at cycle 0.
   - Required: lcd_e=0 for cycles 0..19. First bus value 0x30/rs=0 at cycle 18; lcd_e high during cycles 20..23. Then 0x30, 0x0C, 0x01, two idle slots, 0x06. busy drops after the 0x06 slot.
2. Frame content (ROWS=2, COLS=4):
   - Stimulus: write "ABCD" to addresses 0..3 and "wxyz" to 4..7, then pulse refresh.
   - Required: latched bytes are 0x80, A, B, C, D, 0x90, w, x, y, z, with rs 0,1,1,1,1,0,1,1,1,1.
   - Required: frame_done pulses exactly once, then busy=0.
3. Coalescing:
   - Stimulus: three refresh pulses during one frame.
   - Required: exactly one extra frame, then IDLE.
4. Dirty flag:
   - Stimulus: write address 2 = 0x5A mid-frame, with no refresh.
   - Required: a second frame follows automatically and carries 0x5A at the row-0, col-2 slot.
5. Out-of-range address:
   - Stimulus: write to address ROWS*COLS while idle.
   - Required: no frame starts; buffer contents unchanged.
6. Reset mid-frame and auto-refresh:
   - Stimulus: assert rst during a data slot. Separately, run with AUTO_REFRESH=1.
   - Required on reset: outputs return to reset values the next cycle; init replays. Default (0x20) buffer shows spaces.
   - Required with AUTO_REFRESH=1: frame_done pulses every ROWS*(COLS+1)*2*CLK_DIV cycles; busy stays 1.

Source files
------------

// File: rtl/lcd_text_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : lcd_text_ctrl_if
// Brief   : Host-side text/refresh handshake and 8-bit parallel LCD bus.
// Revision: 1.0 - initial release
// ============================================================================
interface lcd_text_ctrl_if #(
    parameter int AW = 6
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          refresh;
    logic          busy;
    logic          frame_done;
    logic          lcd_rs;
    logic          lcd_rw;
    logic          lcd_e;
    logic [7:0]    lcd_data;

    modport master (
        output wr_en, wr_addr, wr_data, refresh,
        input  busy, frame_done, lcd_rs, lcd_rw, lcd_e, lcd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, refresh,
        output busy, frame_done, lcd_rs, lcd_rw, lcd_e, lcd_data
    );
endinterface
`default_nettype wire

// File: rtl/lcd_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lcd_text_ctrl
// Brief   : ST7920-class text LCD controller: init sequence plus frame streaming
//           of a host-writable ROWS x COLS text buffer over the 8-bit bus.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_text_ctrl #(
    parameter int CLK_DIV      = 8000,
    parameter int ROWS         = 4,
    parameter int COLS         = 16,
    parameter int INIT_SLOTS   = 8,
    parameter int CLEAR_SLOTS  = 6,
    parameter int AUTO_REFRESH = 1
) (
    input wire             clk_50M,
    input wire             rst,
    lcd_text_ctrl_if.slave bus
);
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOT  = 2 * CLK_DIV;
    localparam int SW    = $clog2(SLOT);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = $clog2(COLS + 1);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_INIT_WAIT = 3'd0,
        ST_CMD       = 3'd1,
        ST_CLR_WAIT  = 3'd2,
        ST_ENTRY     = 3'd3,
        ST_IDLE      = 3'd4,
        ST_FRAME     = 3'd5
    } state_t;

    localparam state_t RST_STATE = (INIT_SLOTS > 0) ? ST_INIT_WAIT : ST_CMD;

    state_t           r_state, w_state_nxt;
    logic [SW-1:0]    r_s, w_s_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [RW-1:0]    r_row, w_row_nxt;
    logic [CW-1:0]    r_col, w_col_nxt;
    logic             r_pending, r_dirty;
    logic             r_e, r_rs, r_fd;
    logic [7:0]       r_data;
    logic [7:0]       r_buf [0:DEPTH-1];

    logic             w_wrap, w_wr_ok, w_req, w_start;
    logic             w_is_bus, w_load_rs, w_last_nxt;
    logic [7:0]       w_load_data;
    logic [AW-1:0]    w_rd_addr;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0, 2'd1: init_cmd = 8'h30;
            2'd2:       init_cmd = 8'h0C;
            default:    init_cmd = 8'h01;
        endcase
    endfunction

    // DDRAM start address of each text row (rows 2/3 interleave after 0/1)
    function automatic logic [7:0] row_cmd(input logic [1:0] row);
        case (row)
            2'd0:    row_cmd = 8'h80;
            2'd1:    row_cmd = 8'h90;
            2'd2:    row_cmd = 8'h88;
            default: row_cmd = 8'h98;
        endcase
    endfunction

    assign w_wrap  = (r_s == SW'(SLOT - 1));
    assign w_wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < (AW + 1)'(DEPTH));
    assign w_req   = r_pending || r_dirty || bus.refresh || w_wr_ok;

    always_comb begin
        w_s_nxt     = w_wrap ? '0 : r_s + 1'b1;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_start     = 1'b0;
        if (w_wrap) begin
            case (r_state)
                ST_INIT_WAIT: begin
                    if (r_cnt == CNT_W'(INIT_SLOTS - 1)) begin
                        w_state_nxt = ST_CMD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_CMD: begin
                    if (r_cnt == CNT_W'(3)) begin
                        w_state_nxt = (CLEAR_SLOTS > 0) ? ST_CLR_WAIT : ST_ENTRY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_CLR_WAIT: begin
                    if (r_cnt == CNT_W'(CLEAR_SLOTS - 1)) begin
                        w_state_nxt = ST_ENTRY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_ENTRY: begin
                    w_row_nxt = '0;
                    w_col_nxt = '0;
                    if (AUTO_REFRESH != 0) begin
                        w_state_nxt = ST_FRAME;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_req) begin
                        w_state_nxt = ST_FRAME;
                        w_start     = 1'b1;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                    end
                end
                ST_FRAME: begin
                    if (r_col == CW'(COLS)) begin
                        w_col_nxt = '0;
                        if (r_row == RW'(ROWS - 1)) begin
                            w_row_nxt = '0;
                            if (AUTO_REFRESH != 0 || w_req) begin
                                w_start = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
                default: w_state_nxt = RST_STATE;
            endcase
        end
    end

    // Bus content is derived from the slot about to run, so the register lands
    // exactly on the CLK_DIV/2 setup point; col 0 of a row is its address slot.
    always_comb begin
        w_is_bus    = 1'b0;
        w_load_rs   = 1'b0;
        w_load_data = 8'h00;
        w_rd_addr   = '0;
        case (w_state_nxt)
            ST_CMD: begin
                w_is_bus    = 1'b1;
                w_load_data = init_cmd(w_cnt_nxt[1:0]);
            end
            ST_ENTRY: begin
                w_is_bus    = 1'b1;
                w_load_data = 8'h06;
            end
            ST_FRAME: begin
                w_is_bus = 1'b1;
                if (w_col_nxt == '0) begin
                    w_load_data = row_cmd(2'(w_row_nxt));
                end else begin
                    w_load_rs   = 1'b1;
                    w_rd_addr   = AW'(int'(w_row_nxt) * COLS + int'(w_col_nxt) - 1);
                    w_load_data = r_buf[w_rd_addr];
                end
            end
            default: ;
        endcase
    end

    assign w_last_nxt = (w_state_nxt == ST_FRAME) && (w_row_nxt == RW'(ROWS - 1)) &&
                        (w_col_nxt == CW'(COLS)) && (w_s_nxt == SW'(SLOT - 1));

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state   <= RST_STATE;
            r_s       <= '0;
            r_cnt     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_dirty   <= 1'b0;
            r_e       <= 1'b0;
            r_rs      <= 1'b0;
            r_data    <= 8'h00;
            r_fd      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_e     <= w_is_bus && (w_s_nxt >= SW'(CLK_DIV));
            r_fd    <= w_last_nxt;
            if (w_is_bus && (w_s_nxt == SW'(CLK_DIV / 2))) begin
                r_rs   <= w_load_rs;
                r_data <= w_load_data;
            end
            if (AUTO_REFRESH != 0) begin
                r_pending <= 1'b0;
                r_dirty   <= 1'b0;
            end else begin
                // A write in the start cycle lands before any data slot samples it
                r_pending <= w_start ? 1'b0 : (r_pending || bus.refresh);
                r_dirty   <= w_start ? 1'b0 : (r_dirty || w_wr_ok);
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= 8'h20;
            end
        end else if (w_wr_ok) begin
            r_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.busy       = (r_state != ST_IDLE) || r_pending || r_dirty;
    assign bus.frame_done = r_fd;
    assign bus.lcd_rs     = r_rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = r_e;
    assign bus.lcd_data   = r_data;
endmodule
`default_nettype wire

// File: tb/tb_lcd_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_text_ctrl
// Brief   : Scoreboard bench for lcd_text_ctrl (on-demand and auto-refresh DUTs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_lcd_text_ctrl;
    localparam int CLK_DIV = 4;
    localparam int ROWS    = 4;
    localparam int COLS    = 6;
    localparam int DEPTH   = ROWS * COLS;
    localparam int AW      = $clog2(DEPTH);
    localparam int A_AW    = 3;

    logic clk = 1'b0;
    logic rst;
    logic rst_a;
    always #5 clk = ~clk;

    lcd_text_ctrl_if #(.AW(AW))   bus ();
    lcd_text_ctrl_if #(.AW(A_AW)) bus_a ();

    lcd_text_ctrl #(
        .CLK_DIV(CLK_DIV), .ROWS(ROWS), .COLS(COLS),
        .INIT_SLOTS(2), .CLEAR_SLOTS(2), .AUTO_REFRESH(0)
    ) dut (
        .clk_50M(clk), .rst(rst), .bus(bus)
    );

    lcd_text_ctrl #(
        .CLK_DIV(CLK_DIV), .ROWS(2), .COLS(4),
        .INIT_SLOTS(2), .CLEAR_SLOTS(2), .AUTO_REFRESH(1)
    ) dut_auto (
        .clk_50M(clk), .rst(rst_a), .bus(bus_a)
    );

    int total = 0;
    int bad   = 0;
    int fd_count = 0;
    logic [7:0] model_buf [DEPTH];
    logic [8:0] exp_q [$];
    logic [7:0] row_addr [4] = '{8'h80, 8'h90, 8'h88, 8'h98};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h30});
        exp_q.push_back({1'b0, 8'h30});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_frame();
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back({1'b0, row_addr[r]});
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, model_buf[r*COLS + c]});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_buf[i] = 8'h20;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input logic [7:0] data, input logic with_ref);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        bus.refresh = with_ref;
        if (addr < DEPTH) model_buf[addr] = data;
        tick(1);
        bus.wr_en   = 1'b0;
        bus.refresh = 1'b0;
    endtask

    task automatic pulse_refresh();
        bus.refresh = 1'b1;
        tick(1);
        bus.refresh = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                seen = 1;
                break;
            end
        end
        check({name, "_idle_reached"}, seen, 1);
        tick(1);
    endtask

    // Scoreboard monitor: every falling edge of E is one latched bus transfer
    logic prev_e   = 1'b0;
    logic prev_rst = 1'b1;
    always @(negedge clk) begin
        if (prev_e && !bus.lcd_e && !prev_rst) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL latch_unexpected: got rs=%0d data=0x%0h, required no transfer",
                         bus.lcd_rs, bus.lcd_data);
            end else begin
                check("latch_rs_data", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, exp_q.pop_front()});
                check("latch_rw", bus.lcd_rw, 0);
            end
        end
        if (bus.frame_done && !rst) fd_count++;
        prev_e   = bus.lcd_e;
        prev_rst = rst;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, first_e, e_hi, busy_hi, fd_list[$];
        logic [7:0] d17, d18;
        logic rs18, b71, b72;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'h00; bus.refresh = 1'b0;
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = 8'h00; bus_a.refresh = 1'b0;
        rst = 1'b1; rst_a = 1'b1;
        model_reset();
        tick(3);

        // Reset values
        @(negedge clk);
        check("rst_lcd_e", bus.lcd_e, 0);
        check("rst_lcd_rs", bus.lcd_rs, 0);
        check("rst_lcd_data", bus.lcd_data, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_frame_done", bus.frame_done, 0);
        @(posedge clk); #1;

        // Init timing, cycle 0 = first cycle after release
        push_init();
        rst = 1'b0;
        first_e = -1; e_hi = 0; d17 = 8'hFF; d18 = 8'h00; rs18 = 1'b1; b71 = 1'b0; b72 = 1'b1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (bus.lcd_e && first_e < 0) first_e = n;
            if (n >= 20 && n <= 23 && bus.lcd_e) e_hi++;
            if (n == 17) d17 = bus.lcd_data;
            if (n == 18) begin d18 = bus.lcd_data; rs18 = bus.lcd_rs; end
            if (n == 71) b71 = bus.busy;
            if (n == 72) b72 = bus.busy;
        end
        check("init_first_e_cycle", first_e, 20);
        check("init_e_high_20_23", e_hi, 4);
        check("init_data_c17", d17, 8'h00);
        check("init_data_c18", d18, 8'h30);
        check("init_rs_c18", rs18, 0);
        check("init_busy_c71", b71, 1);
        check("init_busy_c72", b72, 0);
        tick(1);

        // Default buffer shows spaces
        fd0 = fd_count;
        pulse_refresh();
        push_frame();
        wait_idle("spaces", 400);
        check("spaces_frames", fd_count - fd0, 1);

        // Reset in a data slot, then refill during the replayed init
        pulse_refresh();
        push_frame();
        tick(40);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        push_init();
        @(negedge clk);
        check("midrst_lcd_e", bus.lcd_e, 0);
        check("midrst_lcd_rs", bus.lcd_rs, 0);
        check("midrst_lcd_data", bus.lcd_data, 0);
        check("midrst_busy", bus.busy, 1);
        check("midrst_frame_done", bus.frame_done, 0);
        @(posedge clk); #1;
        fd0 = fd_count;
        for (int i = 0; i < DEPTH; i++) write(i, 8'($urandom_range(33, 126)), 1'b0);
        push_frame();
        wait_idle("fill", 800);
        check("fill_frames", fd_count - fd0, 1);

        // Random single writes while idle, optionally with a coincident refresh
        for (int k = 0; k < 6; k++) begin
            fd0 = fd_count;
            tick($urandom_range(0, 9));
            write($urandom_range(0, DEPTH - 1), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            push_frame();
            wait_idle("rand", 400);
            check("rand_frames", fd_count - fd0, 1);
        end

        // Three refresh requests during one frame coalesce to one more frame
        fd0 = fd_count;
        pulse_refresh();
        push_frame();
        tick(30); pulse_refresh();
        tick(20); pulse_refresh();
        tick(20); pulse_refresh();
        push_frame();
        wait_idle("coalesce", 800);
        check("coalesce_frames", fd_count - fd0, 2);

        // Write to row 0 col 2 after that slot has been sent
        fd0 = fd_count;
        pulse_refresh();
        push_frame();
        tick(80);
        write(2, 8'h5A, 1'b0);
        push_frame();
        wait_idle("dirty", 800);
        check("dirty_frames", fd_count - fd0, 2);

        // Out-of-range write while idle
        fd0 = fd_count;
        write(DEPTH + $urandom_range(0, (1 << AW) - DEPTH - 1), 8'($urandom_range(0, 255)), 1'b0);
        busy_hi = 0; e_hi = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.busy) busy_hi++;
            if (bus.lcd_e) e_hi++;
        end
        check("oor_busy_cycles", busy_hi, 0);
        check("oor_e_cycles", e_hi, 0);
        check("oor_frames", fd_count - fd0, 0);
        tick(1);
        pulse_refresh();
        push_frame();
        wait_idle("oor_after", 400);
        check("queue_drained", exp_q.size(), 0);

        // Auto-refresh instance: frame_done every 2*5*8 cycles after a 19-slot lead-in
        rst_a = 1'b0;
        busy_hi = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus_a.frame_done) fd_list.push_back(n);
            if (bus_a.busy) busy_hi++;
        end
        check("auto_frame_count", fd_list.size(), 4);
        if (fd_list.size() > 0) check("auto_first_done", fd_list[0], 151);
        for (int i = 1; i < fd_list.size(); i++) check("auto_period", fd_list[i] - fd_list[i-1], 80);
        check("auto_busy_cycles", busy_hi, 400);
        check("auto_rw", bus_a.lcd_rw, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
